// File: rtl/uop_queue_pkg.sv
// uop_queue_pkg: uop types and queue sizing shared by the decoder, the uop queue and rename.
package uop_queue_pkg;

    localparam int INSTR_Q_DEPTH = 32;
    localparam int INSTR_Q_WIDTH = 5;

    typedef enum logic [3:0] {
        UOP_NOP = 4'd0,
        UOP_ADD = 4'd1,
        UOP_SUB = 4'd2,
        UOP_LD  = 4'd3,
        UOP_ST  = 4'd4,
        UOP_BR  = 4'd5,
        UOP_HLT = 4'd6
    } uop_code;

    typedef struct packed {
        uop_code     uopcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] pc;
    } uop_insn;

    localparam int UOP_W = $bits(uop_insn);

    // True when the raw uop bits carry a halt opcode.
    function automatic logic is_halt(input logic [UOP_W-1:0] raw);
        uop_insn u;
        u = uop_insn'(raw);
        return (u.uopcode == UOP_HLT);
    endfunction

endpackage

// File: rtl/uop_queue_mem.sv
// uop_queue_mem: DEPTH-entry uop storage, one synchronous write port and one
// combinational read port. Kept on its own so the array can map onto a RAM.
module uop_queue_mem
    import uop_queue_pkg::*;
#(
    parameter int DEPTH  = INSTR_Q_DEPTH,
    parameter int ADDR_W = INSTR_Q_WIDTH
) (
    input  logic              clk_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [UOP_W-1:0]  wr_data_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [UOP_W-1:0]  rd_data_o
);

    logic [UOP_W-1:0] mem_q [DEPTH];

    // Write the incoming uop into its slot; storage needs no reset.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/uop_queue.sv
// uop_queue: decoupling FIFO between decode and rename/ROB dispatch.
// valid/ready on both sides, whole-queue flush, enqueue blocked after a HLT
// until the next flush. Pointers carry an extra wrap bit to tell full from empty.
// Optional build macro UOP_QUEUE_BYPASS_EN: an empty queue forwards the offered
// uop to the head in the same cycle.
module uop_queue
    import uop_queue_pkg::*;
#(
    parameter int DEPTH = INSTR_Q_DEPTH,
    parameter int PTR_W = INSTR_Q_WIDTH
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             flush_in,
    input  logic             enq_valid_in,
    input  logic [UOP_W-1:0] enq_uop_in,
    output logic             enq_ready_out,
    output logic             deq_valid_out,
    output logic [UOP_W-1:0] deq_uop_out,
    input  logic             deq_ready_in,
    output logic [PTR_W:0]   count_out,
    output logic             halted_out
);

    localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

    logic [PTR_W:0]   head_q, head_d;
    logic [PTR_W:0]   tail_q, tail_d;
    logic             halt_q, halt_d;

    logic             empty_s;
    logic             full_s;
    logic             enq_ready_s;
    logic             enq_fire_s;
    logic             enq_is_hlt_s;
    logic             deq_valid_s;
    logic             deq_fire_s;
    logic [UOP_W-1:0] deq_uop_s;
    logic             wr_en_s;
    logic             head_adv_s;
    logic [UOP_W-1:0] mem_rd_s;

    uop_queue_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_mem (
        .clk_i     (clk_in),
        .wr_en_i   (wr_en_s),
        .wr_addr_i (tail_q[PTR_W-1:0]),
        .wr_data_i (enq_uop_in),
        .rd_addr_i (head_q[PTR_W-1:0]),
        .rd_data_o (mem_rd_s)
    );

    // Occupancy flags and the enqueue handshake; ready never looks at deq_ready_in.
    always_comb begin
        empty_s      = (head_q == tail_q);
        full_s       = (head_q[PTR_W-1:0] == tail_q[PTR_W-1:0]) &&
                       (head_q[PTR_W] != tail_q[PTR_W]);
        enq_ready_s  = !full_s && !halt_q && !flush_in;
        enq_fire_s   = enq_valid_in && enq_ready_s;
        enq_is_hlt_s = is_halt(enq_uop_in);
    end

`ifdef UOP_QUEUE_BYPASS_EN
    logic byp_s;
    logic pass_s;

    // Dequeue side with same-cycle forwarding: a uop offered to an empty queue
    // is shown at the head; if taken now it never touches storage or pointers.
    always_comb begin
        byp_s       = empty_s && !flush_in && !halt_q && enq_valid_in;
        deq_valid_s = (!empty_s && !flush_in) || byp_s;
        if (byp_s) begin
            deq_uop_s = enq_uop_in;
        end else begin
            deq_uop_s = mem_rd_s;
        end
        deq_fire_s  = deq_valid_s && deq_ready_in;
        pass_s      = byp_s && deq_ready_in;
        wr_en_s     = enq_fire_s && !pass_s;
        head_adv_s  = deq_fire_s && !pass_s;
    end
`else
    // Dequeue side: head comes straight from storage, so a new uop needs a cycle.
    always_comb begin
        deq_valid_s = !empty_s && !flush_in;
        deq_uop_s   = mem_rd_s;
        deq_fire_s  = deq_valid_s && deq_ready_in;
        wr_en_s     = enq_fire_s;
        head_adv_s  = deq_fire_s;
    end
`endif

    // Next pointer and halt state; a flush empties the queue by catching head up to tail.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        halt_d = halt_q;
        if (flush_in) begin
            head_d = tail_q;
            halt_d = 1'b0;
        end else begin
            if (wr_en_s) begin
                tail_d = tail_q + PTR_ONE;
            end else begin
                tail_d = tail_q;
            end
            if (head_adv_s) begin
                head_d = head_q + PTR_ONE;
            end else begin
                head_d = head_q;
            end
            if (enq_fire_s && enq_is_hlt_s) begin
                halt_d = 1'b1;
            end else begin
                halt_d = halt_q;
            end
        end
    end

    // State registers; reset wins over flush and any handshake.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head_q <= {(PTR_W+1){1'b0}};
            tail_q <= {(PTR_W+1){1'b0}};
            halt_q <= 1'b0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            halt_q <= halt_d;
        end
    end

    assign enq_ready_out = enq_ready_s;
    assign deq_valid_out = deq_valid_s;
    assign deq_uop_out   = deq_uop_s;
    assign count_out     = tail_q - head_q;
    assign halted_out    = halt_q;

endmodule

// File: tb/tb_uop_queue.sv
// tb_uop_queue: table-driven vectors, directed multi-cycle sequences and a
// randomized run checked against a queue-based reference model.
module tb_uop_queue;
    import uop_queue_pkg::*;

    localparam int DEPTH = INSTR_Q_DEPTH;
    localparam int PTR_W = INSTR_Q_WIDTH;
`ifdef UOP_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst, flush, ev, dr;
    logic [UOP_W-1:0] enq_uop;
    logic [UOP_W-1:0] deq_uop;
    logic             er, dv, halted;
    logic [PTR_W:0]   cnt;

    uop_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk_in        (clk),
        .rst_in        (rst),
        .flush_in      (flush),
        .enq_valid_in  (ev),
        .enq_uop_in    (enq_uop),
        .enq_ready_out (er),
        .deq_valid_out (dv),
        .deq_uop_out   (deq_uop),
        .deq_ready_in  (dr),
        .count_out     (cnt),
        .halted_out    (halted)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // reference model: contents in order plus the halt flag
    uop_insn mq[$];
    bit      mhalt = 1'b0;
    bit      mchk  = 1'b0;

    typedef struct {
        bit          r, f, v, d;
        uop_code     op;
        logic [31:0] pc;
        bit          e_dv, e_er, e_h;
        int          e_cnt;
        logic [31:0] e_pc;
    } vec_t;

    function automatic vec_t row(bit r, bit f, bit v, uop_code op, logic [31:0] pc, bit d,
                                 bit e_dv, int e_cnt, bit e_er, bit e_h, logic [31:0] e_pc);
        vec_t t;
        t.r = r; t.f = f; t.v = v; t.op = op; t.pc = pc; t.d = d;
        t.e_dv = e_dv; t.e_cnt = e_cnt; t.e_er = e_er; t.e_h = e_h; t.e_pc = e_pc;
        return t;
    endfunction

    function automatic uop_insn mk(uop_code op, logic [31:0] pc);
        uop_insn u;
        u.uopcode = op;
        u.rd      = pc[6:2];
        u.rs1     = pc[11:7];
        u.rs2     = pc[16:12];
        u.pc      = pc;
        return u;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] head_pc();
        uop_insn h;
        h = uop_insn'(deq_uop);
        return h.pc;
    endfunction

    // One clock: drive at negedge, sample 1 time unit later, advance the model.
    task automatic cycle(input bit r, input bit f, input bit v, input uop_insn u, input bit d);
        int sz;
        bit acc, pass, e_dv;
        @(negedge clk);
        rst = r; flush = f; ev = v; enq_uop = u; dr = d;
        #1;
        sz = mq.size();
        if (mchk) begin
            e_dv = !f && (sz > 0 || (BYP && v && !mhalt));
            chk("m_enq_ready", 64'(er), 64'(!f && !mhalt && sz < DEPTH));
            chk("m_deq_valid", 64'(dv), 64'(e_dv));
            chk("m_count", 64'(cnt), 64'(sz));
            chk("m_halted", 64'(halted), 64'(mhalt));
            if (e_dv) begin
                chk("m_head", 64'(deq_uop), (sz > 0) ? 64'(mq[0]) : 64'(u));
            end
        end
        if (r || f) begin
            mq.delete();
            mhalt = 1'b0;
        end else begin
            acc  = v && (sz < DEPTH) && !mhalt;
            pass = BYP && acc && d && (sz == 0);
            if (!pass && d && sz > 0) void'(mq.pop_front());
            if (acc && !pass) mq.push_back(u);
            if (acc && u.uopcode == UOP_HLT) mhalt = 1'b1;
        end
    endtask

    initial begin
        vec_t    tbl[13];
        uop_insn idle;
        int      ne, nd;
        idle = mk(UOP_NOP, 32'h0);
        rst = 1'b1; flush = 1'b0; ev = 1'b0; dr = 1'b0; enq_uop = '0;

        // reset/idle, HLT blocking and first-uop latency
        tbl[0]  = row(1, 0, 0, UOP_NOP, 32'h0,   0, 0, 0, 0, 0, 32'h0);
        tbl[1]  = row(1, 1, 1, UOP_ADD, 32'h50,  1, 0, 0, 0, 0, 32'h0);
        tbl[2]  = row(0, 0, 0, UOP_NOP, 32'h0,   0, 0, 0, 1, 0, 32'h0);
        tbl[3]  = row(0, 0, 1, UOP_ADD, 32'h100, 0, BYP, 0, 1, 0, 32'h100);
        tbl[4]  = row(0, 0, 1, UOP_HLT, 32'h104, 0, 1, 1, 1, 0, 32'h100);
        tbl[5]  = row(0, 0, 1, UOP_ADD, 32'h108, 0, 1, 2, 0, 1, 32'h100);
        tbl[6]  = row(0, 0, 0, UOP_NOP, 32'h0,   1, 1, 2, 0, 1, 32'h100);
        tbl[7]  = row(0, 0, 0, UOP_NOP, 32'h0,   1, 1, 1, 0, 1, 32'h104);
        tbl[8]  = row(0, 0, 0, UOP_NOP, 32'h0,   1, 0, 0, 0, 1, 32'h0);
        tbl[9]  = row(0, 1, 0, UOP_NOP, 32'h0,   0, 0, 0, 0, 1, 32'h0);
        tbl[10] = row(0, 0, 0, UOP_NOP, 32'h0,   0, 0, 0, 1, 0, 32'h0);
        tbl[11] = row(0, 0, 1, UOP_ADD, 32'h2000, 1, BYP, 0, 1, 0, 32'h2000);
        tbl[12] = row(0, 0, 0, UOP_NOP, 32'h0,   0, !BYP, BYP ? 0 : 1, 1, 0, 32'h2000);

        for (int i = 0; i < 13; i++) begin
            cycle(tbl[i].r, tbl[i].f, tbl[i].v, mk(tbl[i].op, tbl[i].pc), tbl[i].d);
            if (i > 0) begin
                chk($sformatf("t%0d_deq_valid", i), 64'(dv), 64'(tbl[i].e_dv));
                chk($sformatf("t%0d_count", i), 64'(cnt), 64'(tbl[i].e_cnt));
                chk($sformatf("t%0d_enq_ready", i), 64'(er), 64'(tbl[i].e_er));
                chk($sformatf("t%0d_halted", i), 64'(halted), 64'(tbl[i].e_h));
                if (tbl[i].e_dv) chk($sformatf("t%0d_pc", i), 64'(head_pc()), 64'(tbl[i].e_pc));
            end
        end

        // fill to 32 entries, then drain in order
        cycle(1, 0, 0, idle, 0);
        for (int i = 0; i < DEPTH; i++) begin
            cycle(0, 0, 1, mk(UOP_ADD, 32'h1000 + 32'(4 * i)), 0);
            chk("fill_enq_ready", 64'(er), 64'(1'b1));
        end
        cycle(0, 0, 0, idle, 0);
        chk("full_count", 64'(cnt), 64'(DEPTH));
        chk("full_enq_ready", 64'(er), 64'(1'b0));
        for (int i = 0; i < DEPTH; i++) begin
            cycle(0, 0, (i == 0), mk(UOP_ADD, 32'hBAD), 1);
            if (i == 0) chk("full_ready_with_deq", 64'(er), 64'(1'b0));
            chk("drain_valid", 64'(dv), 64'(1'b1));
            chk("drain_pc", 64'(head_pc()), 64'(32'h1000 + 32'(4 * i)));
            chk("drain_count", 64'(cnt), 64'(DEPTH - i));
        end
        cycle(0, 0, 0, idle, 0);
        chk("drained_count", 64'(cnt), 64'(0));
        chk("drained_valid", 64'(dv), 64'(1'b0));

        // three resident entries, 100 cycles of concurrent enq/deq across the wrap
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, mk(UOP_SUB, 32'h3000 + 32'(4 * i)), 0);
        ne = 3; nd = 0;
        for (int k = 0; k < 100; k++) begin
            cycle(0, 0, 1, mk(UOP_SUB, 32'h3000 + 32'(4 * ne)), 1);
            chk("conc_count", 64'(cnt), 64'(3));
            chk("conc_pc", 64'(head_pc()), 64'(32'h3000 + 32'(4 * nd)));
            ne++; nd++;
        end
        for (int k = 0; k < 3; k++) begin
            cycle(0, 0, 0, idle, 1);
            chk("conc_tail_pc", 64'(head_pc()), 64'(32'h3000 + 32'(4 * nd)));
            nd++;
        end
        cycle(0, 0, 0, idle, 0);
        chk("conc_empty", 64'(cnt), 64'(0));

        // flush with 10 queued while the decoder is still offering
        for (int i = 0; i < 10; i++) cycle(0, 0, 1, mk(UOP_LD, 32'h4000 + 32'(4 * i)), 0);
        cycle(0, 1, 1, mk(UOP_ADD, 32'hDEAD), 1);
        chk("flush_deq_valid", 64'(dv), 64'(1'b0));
        chk("flush_enq_ready", 64'(er), 64'(1'b0));
        cycle(0, 0, 0, idle, 0);
        chk("post_flush_count", 64'(cnt), 64'(0));
        chk("post_flush_valid", 64'(dv), 64'(1'b0));
        chk("post_flush_ready", 64'(er), 64'(1'b1));
        cycle(0, 0, 1, mk(UOP_ST, 32'h5000), 0);
        cycle(0, 0, 0, idle, 0);
        chk("post_flush_one", 64'(cnt), 64'(1));
        chk("post_flush_pc", 64'(head_pc()), 64'(32'h5000));
        cycle(0, 0, 0, idle, 1);

        // randomized traffic against the reference model
        mchk = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            uop_code op;
            int      rdy_pct;
            op = ($urandom_range(0, 99) < 2) ? UOP_HLT : uop_code'($urandom_range(0, 5));
            rdy_pct = ((k / 400) % 2 == 0) ? 25 : 80;
            cycle(($urandom_range(0, 299) == 0),
                  ($urandom_range(0, 99) < 2),
                  ($urandom_range(0, 99) < 70),
                  mk(op, $urandom),
                  ($urandom_range(0, 99) < rdy_pct));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uop_queue.md
Name: uop_queue

Overview:
- Decoupling FIFO between the decoder (producer of uop_insn) and rename/ROB dispatch (consumer).
- Absorbs decode bursts and backpressure with valid/ready handshakes on both sides.
- Supports whole-queue flush on branch mispredict or exception.
- Blocks further enqueue once a UOP_HLT has been accepted, until flushed.

Parameters:
- DEPTH, default INSTR_Q_DEPTH (32): number of entries; must be a power of 2, minimum 2.
- PTR_W, default INSTR_Q_WIDTH (5): pointer width; must equal log2(DEPTH).

Ports:
- clk_in  input  1  clock; all state updates on the rising edge.
- rst_in  input  1  synchronous, active-high reset.
- flush_in  input  1  discard all contents this cycle.
- enq_valid_in  input  1  decoder presents a uop.
- enq_uop_in  input  $bits(uop_insn)  uop being enqueued.
- enq_ready_out  output  1  queue accepts the uop this cycle.
- deq_valid_out  output  1  head entry is valid.
- deq_uop_out  output  $bits(uop_insn)  head uop.
- deq_ready_in  input  1  consumer takes the head this cycle.
- count_out  output  PTR_W+1  current occupancy, 0..DEPTH.
- halted_out  output  1  a UOP_HLT has been accepted and no flush has occurred since.

Behaviour:
- State: head_ptr, tail_ptr (PTR_W+1 bits each; the extra MSB is the wrap bit), storage array of DEPTH uop_insn, halt_seen flag.
- empty: head_ptr == tail_ptr. full: low PTR_W bits equal and MSBs differ. count_out = tail_ptr - head_ptr, modulo 2^(PTR_W+1).
- Reset (rst_in high at the clock edge):
  - Pointers and halt_seen go to 0.
  - Outputs after reset: deq_valid_out=0, count_out=0, halted_out=0, enq_ready_out=1.
  - deq_uop_out is don't-care while deq_valid_out=0.
  - Reset overrides flush and any handshake in the same cycle, including mid-burst.
- Enqueue:
  - enq_ready_out = !full && !halt_seen && !flush_in.
  - On enq_valid_in && enq_ready_out: write enq_uop_in at tail, tail_ptr += 1.
  - If enq_uop_in.uopcode == UOP_HLT on an accepted enqueue, halt_seen <= 1 next cycle.
- Dequeue:
  - deq_valid_out = !empty && !flush_in.
  - deq_uop_out = storage[head_ptr[PTR_W-1:0]]; combinational read, no output register.
  - On deq_valid_out && deq_ready_in: head_ptr += 1.
- Latency: an entry enqueued in cycle N is visible at the head no earlier than cycle N+1.
- Simultaneous enqueue and dequeue:
  - Both are allowed in the same cycle; count is unchanged.
  - When full, enq_ready_out=0 even if deq_ready_in=1. There is no same-cycle slot reuse.
- Empty queue with enq_valid_in: deq_valid_out stays 0 that cycle (unless the bypass feature below is compiled in).
- Wrap-around: the pointer low bits wrap from DEPTH-1 to 0. The MSB toggles on each wrap, which distinguishes full from empty.
- Flush (flush_in high, rst_in low):
  - Next cycle: head_ptr <= tail_ptr (queue becomes empty) and halt_seen <= 0.
  - In the flush cycle, enq_ready_out=0 and deq_valid_out=0, so no handshake completes.
- halted_out = halt_seen.
- Entries behind a HLT are impossible, because enq_ready_out drops the cycle after HLT acceptance. The HLT itself and all older entries still drain normally.
- enq_ready_out never depends on deq_ready_in, so there is no combinational ready loop.

Optional Feature:
- Macro: UOP_QUEUE_BYPASS_EN.
- With the macro defined:
  - When empty, !flush_in, !halt_seen and enq_valid_in: deq_valid_out=1 and deq_uop_out=enq_uop_in in the same cycle.
  - If deq_ready_in is also high, the uop passes through; pointers and count are unchanged.
  - If deq_ready_in is low, the uop is written normally.
  - A HLT that passes through still sets halt_seen.
- Without the macro: minimum one-cycle latency as described under Behaviour. The enq-to-deq combinational path does not exist.

Decomposition:
- The shared uop package already supplies uop_insn, uop_code (including UOP_HLT), INSTR_Q_DEPTH and INSTR_Q_WIDTH. Add nothing locally.
- One natural sub-module: uop_queue_mem.
  - DEPTH x $bits(uop_insn) storage with one synchronous write port and one combinational read port.
  - Keeps the array separable for RAM inference.
- The pointer, flag and handshake logic stays in uop_queue.

Test Plan:
- Reset then idle: after rst_in is held 2 cycles → deq_valid_out=0, count_out=0, enq_ready_out=1, halted_out=0.
- Fill and drain: enqueue 32 uops with pc=0x1000+4*i while deq_ready_in=0.
  - Required: enq_ready_out=0 after the 32nd, count_out=32.
  - Then deq_ready_in=1: pc values emerge in order 0x1000..0x107C, count_out falls to 0.
- Wrap and concurrency: keep 3 entries resident and run 100 cycles of simultaneous enq and deq → count_out stays 3, in-order pcs across the pointer wrap, no loss or duplication.
- Flush mid-burst: with 10 entries queued, pulse flush_in for 1 cycle while enq_valid_in=1.
  - Flush cycle: deq_valid_out=0, enq_ready_out=0.
  - Next cycle: count_out=0; the uop offered during flush is not stored.
- HLT block: enqueue ADD, HLT, ADD.
  - Required: the second ADD is refused (enq_ready_out=0), halted_out=1, ADD and HLT drain in order.
  - After flush_in: halted_out=0, enq_ready_out=1.
- Bypass (UOP_QUEUE_BYPASS_EN): empty queue, enq_valid_in=deq_ready_in=1, pc=0x2000.
  - Required: same cycle deq_valid_out=1 and deq_uop_out.pc=0x2000; count_out stays 0.
  - Without the macro: the uop appears at the head one cycle later.
